// File: rtl/core_dmem_responder.sv
// core_dmem_responder: target end of the dmem request/grant bus. It accepts one
// load or store, waits WAIT_CYCLES, and answers with a single-cycle grant
// carrying error status and read data from an internal word-addressed array.

// Per-byte-lane store merge: keep the old byte unless this lane is strobed.
module core_dmem_responder_lane (
  input  logic       strb,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);
  assign merged = strb ? new_byte : old_byte;
endmodule

module core_dmem_responder #(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       ADDR_W      = 64,
  parameter int unsigned       DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned       WAIT_CYCLES = 1
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                dmem_req,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic                dmem_wen,
  input  logic [DATA_W/8-1:0] dmem_strb,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic                dmem_gnt,
  output logic                dmem_err,
  output logic [DATA_W-1:0]   dmem_rdata
);
  localparam int unsigned       NUM_LANES = DATA_W / 8;
  localparam int unsigned       OFF_W     = $clog2(NUM_LANES);
  localparam int unsigned       IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(DEPTH * NUM_LANES);
  localparam logic [3:0]        WC        = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]          addr;
    logic                       wen;
    logic [NUM_LANES-1:0]       strb;
    logic [NUM_LANES-1:0][7:0]  wdata;
  } req_t;

  state_t     state;
  logic [3:0] cnt;
  req_t       req_in, cap, acc;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];
  logic [NUM_LANES-1:0][7:0] old_word, merged;

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic              in_rng;
  logic              go_resp;
  logic              unused_off;

  assign req_in = {dmem_addr, dmem_wen, dmem_strb, dmem_wdata};

  // The access being decided: live bus fields in IDLE (zero-wait case enters
  // RESP on the accepting edge), captured fields once the access is owned.
  assign acc = (state == IDLE) ? req_in : cap;

  assign off        = acc.addr - BASE_ADDR;
  assign in_rng     = (acc.addr >= BASE_ADDR) && (off < SPAN);
  assign idx        = off[OFF_W +: IDX_W];
  assign unused_off = ^{off[OFF_W-1:0], off[ADDR_W-1:OFF_W+IDX_W]};
  assign old_word   = mem[idx];

  // Edge that enters RESP: this is where the array is read and err/rdata registered.
  assign go_resp = dmem_req &&
                   (((state == IDLE) && (WC == 4'd0)) ||
                    ((state == WAIT) && (cnt == 4'd1)));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    core_dmem_responder_lane u_lane (
      .strb     (cap.strb[i]),
      .old_byte (old_word[i]),
      .new_byte (cap.wdata[i]),
      .merged   (merged[i])
    );
  end

  // Access FSM with registered grant, error and read data.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      cap        <= '0;
      dmem_gnt   <= 1'b0;
      dmem_err   <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      dmem_gnt   <= go_resp;
      dmem_err   <= go_resp && !in_rng;
      dmem_rdata <= (go_resp && in_rng && !acc.wen) ? old_word : '0;
      case (state)
        IDLE: begin
          if (dmem_req) begin
            cap <= req_in;
            if (WC == 4'd0) begin
              state <= RESP;
            end else begin
              cnt   <= WC;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Dropping the request mid-wait abandons the access silently.
          if (!dmem_req)          state <= IDLE;
          else if (cnt == 4'd1)   state <= RESP;
          else                    cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Store commit on the edge that ends RESP; array is never reset.
  always_ff @(posedge g_clk) begin
    if ((state == RESP) && cap.wen && in_rng) mem[idx] <= merged;
  end

endmodule

// File: tb/tb_core_dmem_responder.sv
// Bench for core_dmem_responder: four instances (WAIT_CYCLES 0,1,5,15) driven
// by a vector table, hand-written abort/reset sequences, and random accesses
// checked against a byte-level memory model.
module tb_core_dmem_responder;
  localparam int          NI   = 4;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SPAN = 64'd8192;

  logic                 g_clk = 1'b0;
  logic                 g_resetn;
  logic [NI-1:0]        req;
  logic [NI-1:0][63:0]  addr;
  logic [NI-1:0]        wen;
  logic [NI-1:0][7:0]   strb;
  logic [NI-1:0][63:0]  wdata;
  logic [NI-1:0]        gnt;
  logic [NI-1:0]        err;
  logic [NI-1:0][63:0]  rdata;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference memory: contents plus which bytes have ever been written.
  logic [63:0] mm [NI][1024];
  logic [7:0]  kn [NI][1024];

  always #5 g_clk = ~g_clk;

  function automatic int wc_of(int k);
    case (k)
      0:       return 0;
      1:       return 1;
      2:       return 5;
      default: return 15;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WC = wc_of(g);
    core_dmem_responder #(.WAIT_CYCLES(WC)) u_dut (
      .g_clk      (g_clk),
      .g_resetn   (g_resetn),
      .dmem_req   (req[g]),
      .dmem_addr  (addr[g]),
      .dmem_wen   (wen[g]),
      .dmem_strb  (strb[g]),
      .dmem_wdata (wdata[g]),
      .dmem_gnt   (gnt[g]),
      .dmem_err   (err[g]),
      .dmem_rdata (rdata[g])
    );
  end

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit in_rng(logic [63:0] a);
    return (a >= BASE) && (a < BASE + SPAN);
  endfunction

  function automatic int widx(logic [63:0] a);
    logic [63:0] w;
    w = (a - BASE) / 8;
    return int'(w);
  endfunction

  function automatic logic [63:0] mask64(logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // One access on instance k; fields are scrambled after acceptance.
  task automatic run_access(int k, logic [63:0] a, bit w, logic [7:0] s, logic [63:0] d,
                            bit exp_err, logic [63:0] exp_rd, logic [63:0] rd_mask, string nm);
    int lat;
    logic e;
    logic [63:0] r;
    int wi;
    req[k] = 1'b1; addr[k] = a; wen[k] = w; strb[k] = s; wdata[k] = d;
    @(posedge g_clk); #1;
    addr[k]  = {$urandom, $urandom};
    wen[k]   = 1'($urandom);
    strb[k]  = 8'($urandom);
    wdata[k] = {$urandom, $urandom};
    lat = -1; e = 1'b0; r = '0;
    for (int n = 0; n <= 20 && lat < 0; n++) begin
      if (n > 0) begin @(posedge g_clk); #1; end
      if (gnt[k]) begin lat = n; e = err[k]; r = rdata[k]; end
    end
    req[k] = 1'b0;
    check($sformatf("%s i%0d latency", nm, k), 64'(lat), 64'(wc_of(k)));
    check($sformatf("%s i%0d err", nm, k), 64'(e), 64'(exp_err));
    check($sformatf("%s i%0d rdata", nm, k), r & rd_mask, exp_rd & rd_mask);
    @(posedge g_clk); #1;
    check($sformatf("%s i%0d gnt after pulse", nm, k), 64'(gnt[k]), 64'd0);
    check($sformatf("%s i%0d err|rdata after pulse", nm, k), rdata[k] | 64'(err[k]), 64'd0);
    if (w && in_rng(a)) begin
      wi = widx(a);
      for (int i = 0; i < 8; i++)
        if (s[i]) mm[k][wi][8*i +: 8] = d[8*i +: 8];
      kn[k][wi] = kn[k][wi] | s;
    end
  endtask

  // Access whose expectation comes from the reference model.
  task automatic model_access(int k, logic [63:0] a, bit w, logic [7:0] s, logic [63:0] d, string nm);
    logic [63:0] exp_rd, msk;
    exp_rd = '0; msk = '1;
    if (!w && in_rng(a)) begin
      exp_rd = mm[k][widx(a)];
      msk    = mask64(kn[k][widx(a)]);
    end
    run_access(k, a, w, s, d, !in_rng(a), exp_rd, msk, nm);
  endtask

  typedef struct {
    logic [63:0] a;
    bit          w;
    logic [7:0]  s;
    logic [63:0] d;
    bit          e;
    logic [63:0] rd;
  } vec_t;

  vec_t vt [14];

  initial begin
    logic [63:0] a;
    int last, pulses;
    bit gseen;
    vt[0]  = '{64'h8000_0010, 1'b1, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0};
    vt[1]  = '{64'h8000_0010, 1'b0, 8'h00, 64'h0,                   1'b0, 64'h1122_3344_5566_7788};
    vt[2]  = '{64'h8000_0010, 1'b1, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'h0};
    vt[3]  = '{64'h8000_0010, 1'b0, 8'h00, 64'h0,                   1'b0, 64'h1122_3344_AAAA_AAAA};
    vt[4]  = '{64'h8000_0000, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
    vt[5]  = '{64'h8000_2000, 1'b0, 8'h00, 64'h0,                   1'b1, 64'h0};
    vt[6]  = '{64'h7FFF_FFF8, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};
    vt[7]  = '{64'h8000_0000, 1'b0, 8'h00, 64'h0,                   1'b0, 64'h0123_4567_89AB_CDEF};
    vt[8]  = '{64'h8000_0010, 1'b1, 8'h00, 64'h5555_5555_5555_5555, 1'b0, 64'h0};
    vt[9]  = '{64'h8000_0013, 1'b0, 8'h00, 64'h0,                   1'b0, 64'h1122_3344_AAAA_AAAA};
    vt[10] = '{64'h8000_1FF8, 1'b1, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b0, 64'h0};
    vt[11] = '{64'h8000_1FFF, 1'b0, 8'h00, 64'h0,                   1'b0, 64'hCAFE_F00D_1234_5678};
    vt[12] = '{64'h8000_1FF8, 1'b1, 8'h81, 64'h0,                   1'b0, 64'h0};
    vt[13] = '{64'h8000_1FF8, 1'b0, 8'h00, 64'h0,                   1'b0, 64'h00FE_F00D_1234_5600};

    for (int k = 0; k < NI; k++)
      for (int j = 0; j < 1024; j++) begin mm[k][j] = '0; kn[k][j] = '0; end

    g_resetn = 1'b0;
    req = '0; addr = '0; wen = '0; strb = '0; wdata = '0;
    repeat (2) @(posedge g_clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset i%0d gnt", k), 64'(gnt[k]), 64'd0);
      check($sformatf("reset i%0d err|rdata", k), rdata[k] | 64'(err[k]), 64'd0);
    end
    g_resetn = 1'b1;
    @(posedge g_clk); #1;

    // Vector table on every wait-state setting.
    for (int k = 0; k < NI; k++)
      for (int v = 0; v < 14; v++)
        run_access(k, vt[v].a, vt[v].w, vt[v].s, vt[v].d, vt[v].e, vt[v].rd, '1,
                   $sformatf("vec%0d", v));

    // Back-to-back loads with req held high: grants spaced WAIT_CYCLES+2.
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b1; wen[k] = 1'b0; addr[k] = BASE; strb[k] = '0; wdata[k] = '0;
      last = -1; pulses = 0;
      for (int n = 0; n < 4 * (wc_of(k) + 2); n++) begin
        @(posedge g_clk); #1;
        if (gnt[k]) begin
          if (last >= 0)
            check($sformatf("b2b i%0d spacing", k), 64'(n - last), 64'(wc_of(k) + 2));
          else
            check($sformatf("b2b i%0d first latency", k), 64'(n), 64'(wc_of(k)));
          last = n; pulses++;
        end
      end
      req[k] = 1'b0;
      check($sformatf("b2b i%0d pulse count", k), 64'(pulses), 64'd4);
      @(posedge g_clk); #1;
    end

    // Abort: store dropped in the 2nd wait cycle of the 5-wait instance.
    req[2] = 1'b1; addr[2] = BASE + 64'h10; wen[2] = 1'b1; strb[2] = 8'hFF;
    wdata[2] = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge g_clk); #1;
    @(posedge g_clk); #1;
    req[2] = 1'b0;
    gseen = 1'b0;
    for (int n = 0; n < 12; n++) begin @(posedge g_clk); #1; gseen |= gnt[2]; end
    check("abort i2 no gnt", 64'(gseen), 64'd0);
    model_access(2, BASE + 64'h10, 1'b0, 8'h00, 64'h0, "abort reload");

    // Async reset during WAIT of a store on the 15-wait instance.
    req[3] = 1'b1; addr[3] = BASE + 64'h10; wen[3] = 1'b1; strb[3] = 8'hFF;
    wdata[3] = 64'h5A5A_5A5A_5A5A_5A5A;
    repeat (3) begin @(posedge g_clk); #1; end
    #3 g_resetn = 1'b0;
    #1;
    check("rst-wait i3 gnt", 64'(gnt[3]), 64'd0);
    check("rst-wait i3 err|rdata", rdata[3] | 64'(err[3]), 64'd0);
    req[3] = 1'b0;
    @(posedge g_clk); #4 g_resetn = 1'b1;
    @(posedge g_clk); #1;
    model_access(3, BASE + 64'h10, 1'b0, 8'h00, 64'h0, "rst-wait reload");

    // Async reset during RESP of a store on the 0-wait instance.
    req[0] = 1'b1; addr[0] = BASE + 64'h10; wen[0] = 1'b1; strb[0] = 8'hFF;
    wdata[0] = 64'h7777_6666_5555_4444;
    @(posedge g_clk); #1;
    check("rst-resp i0 gnt before reset", 64'(gnt[0]), 64'd1);
    #3 g_resetn = 1'b0;
    #1;
    check("rst-resp i0 gnt", 64'(gnt[0]), 64'd0);
    check("rst-resp i0 err|rdata", rdata[0] | 64'(err[0]), 64'd0);
    req[0] = 1'b0;
    @(posedge g_clk); #4 g_resetn = 1'b1;
    @(posedge g_clk); #1;
    model_access(0, BASE + 64'h10, 1'b0, 8'h00, 64'h0, "rst-resp reload");

    // Random accesses against the model.
    for (int k = 0; k < NI; k++)
      for (int t = 0; t < 25; t++) begin
        case ($urandom_range(0, 9))
          8:       a = BASE + SPAN + 64'(8 * $urandom_range(0, 3)) + 64'($urandom_range(0, 7));
          9:       a = BASE - 64'(8 * $urandom_range(1, 4));
          default: a = BASE + 64'(8 * $urandom_range(0, 7)) + 64'($urandom_range(0, 7));
        endcase
        model_access(k, a, 1'($urandom), 8'($urandom), {$urandom, $urandom},
                     $sformatf("rand%0d", t));
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_dmem_responder.md
# core_dmem_responder

Data-memory responder: the target end of the core's `dmem_*` request/grant bus. It accepts load and store requests issued by the execute stage, services them from an internal word-addressed SRAM array after a configurable number of wait states, and answers each accepted request with exactly one single-cycle `dmem_gnt` carrying error status and read data. It is used as the tightly-coupled data RAM in simulation and small FPGA builds, and as the bus model in execute-stage benches.

## Interface

Parameters:
- `DATA_W`, 64, data bus width in bits; must equal the core's memory data width.
- `ADDR_W`, 64, address width in bits.
- `DEPTH`, 1024, number of `DATA_W` words in the array; power of two.
- `BASE_ADDR`, 64'h8000_0000, byte address of word 0; `DATA_W/8`-aligned.
- `WAIT_CYCLES`, 1, extra wait-state cycles per access; legal range 0..15.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `g_clk` in 1 global clock
- `g_resetn` in 1 global reset, asynchronous, active-low
- `dmem_req` in 1 request valid
- `dmem_addr` in `ADDR_W` request byte address
- `dmem_wen` in 1 1 = store, 0 = load
- `dmem_strb` in `DATA_W/8` store byte-lane strobes
- `dmem_wdata` in `DATA_W` store data
- `dmem_gnt` out 1 response valid, single-cycle pulse
- `dmem_err` out 1 response error, qualified by `dmem_gnt`
- `dmem_rdata` out `DATA_W` load data, qualified by `dmem_gnt`

## Operation

- FSM states: IDLE, WAIT, RESP. Reset state: IDLE.
- IDLE: when `dmem_req`=1, capture addr/wen/strb/wdata (acceptance). If `WAIT_CYCLES`=0, go to RESP; otherwise load a 4-bit counter with `WAIT_CYCLES` and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 1, go to RESP. If `dmem_req`=0 in any WAIT cycle, the access is aborted: go to IDLE, no gnt, no write.
- RESP: `dmem_gnt`=1 for exactly this cycle, then unconditionally go to IDLE. A request present in the following IDLE cycle is a new request.
- Request fields changing after acceptance are ignored; the captured values are used.
- Range check on the captured address: in range iff `BASE_ADDR` <= addr < `BASE_ADDR + DEPTH*DATA_W/8`. Word index = (addr - `BASE_ADDR`) >> log2(`DATA_W/8`). The low address bits are ignored; lane selection uses the strobes only.
- Out of range: `dmem_err`=1, no array write, `dmem_rdata`=0.
- Load in range: `dmem_rdata` = array word, `dmem_err`=0.
- Store in range: for each lane i with `strb[i]`=1, byte i of the word is replaced from `wdata`. `dmem_err`=0 and `dmem_rdata`=0. A store with `strb`=0 is legal, writes nothing, and still grants.
- Array contents are not reset and start undefined.

## Timing

- All outputs are registered. Reset values: `dmem_gnt`=0, `dmem_err`=0, `dmem_rdata`=0.
- Latency: request accepted at edge 0; `dmem_gnt` is high in cycle `WAIT_CYCLES`+1.
- Throughput: at most one access per `WAIT_CYCLES`+2 cycles.
- The array read is performed on the edge that enters RESP, and `rdata`/`err` are registered on that same edge.
- A store commits on the edge that ends the RESP cycle. A load accepted afterwards returns the new data.
- `dmem_err` and `dmem_rdata` return to 0 in every cycle where `dmem_gnt`=0.
- Reset asserted mid-access (WAIT or RESP) takes effect immediately. The FSM goes to IDLE, outputs go to reset values, and a pending store is dropped. Array contents already written are retained.

## Test plan

- Store/load round trip (`WAIT_CYCLES`=1): store 0x1122_3344_5566_7788 to 0x8000_0010 with `strb`=0xFF, then load 0x8000_0010. Required: gnt in cycle 2 after each acceptance, err=0, load rdata=0x1122_3344_5566_7788.
- Partial strobe: after the round trip above, store 0xAAAA_AAAA_AAAA_AAAA with `strb`=0x0F, then load. Required: rdata=0x1122_3344_AAAA_AAAA.
- Out of range: load 0x8000_2000 and store to 0x7FFF_FFF8. Required: each grants with err=1 and rdata=0; a subsequent load of 0x8000_0000 shows no change.
- Latency sweep over `WAIT_CYCLES` = 0, 1, 5, 15. Required: gnt exactly `WAIT_CYCLES`+1 cycles after acceptance, one pulse only, and back-to-back requests spaced `WAIT_CYCLES`+2 cycles apart.
- Abort (`WAIT_CYCLES`=5): store accepted, then `dmem_req` dropped in the 2nd WAIT cycle. Required: no gnt, and a subsequent load returns the old data.
- Async reset: assert `g_resetn`=0 mid-cycle during WAIT of a store. Required: gnt/err/rdata go to 0 before the next edge, the FSM returns to IDLE, and the store is not committed.
